// File: rtl/uart_pkg.sv
// Shared UART definitions: TX state encoding, parity helper, legal parameter ranges.
package uart_pkg;

  // Legal frame-format ranges, shared with the RX side.
  localparam int SIZE_MIN      = 5;
  localparam int SIZE_MAX      = 9;
  localparam int STOP_BITS_MIN = 1;
  localparam int STOP_BITS_MAX = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  // Parity over a zero-extended word; zero padding does not change the XOR.
  // odd=0 gives even parity (bit makes total ones even), odd=1 gives odd parity.
  function automatic logic calc_parity(input logic [SIZE_MAX-1:0] word, input logic odd);
    return (^word) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_shifter.sv
// TX datapath: frame shift register, data-bit counter and parity captured at load.
module uart_tx_shifter
  import uart_pkg::*;
#(
  parameter int SIZE       = 8,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_load,     // take a new word from the holding register
  input  logic            i_shift,    // advance to the next data bit
  input  logic            i_clr_cnt,  // restart the bit counter at the first data bit
  input  logic [SIZE-1:0] i_data,
  output logic            o_bit0,     // bit currently at the LSB of the shifter
  output logic            o_bit1,     // bit that becomes the LSB after the next shift
  output logic            o_last,     // counter is on the final data bit
  output logic            o_par       // parity of the loaded word
);

  localparam int CNT_W = $clog2(SIZE);

  logic [SIZE-1:0]  r_shift;
  logic [CNT_W-1:0] r_bit_cnt;
  logic             r_par;

  // Load / shift register; parity is frozen at load so it tracks the word, not the shifter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_par     <= 1'b0;
    end else if (i_load) begin
      r_shift   <= i_data;
      r_bit_cnt <= '0;
      r_par     <= calc_parity(SIZE_MAX'(i_data), PARITY_ODD);
    end else if (i_shift) begin
      r_shift   <= {1'b0, r_shift[SIZE-1:1]};
      r_bit_cnt <= r_bit_cnt + CNT_W'(1);
    end else if (i_clr_cnt) begin
      r_bit_cnt <= '0;
    end
  end

  assign o_bit0 = r_shift[0];
  assign o_bit1 = r_shift[1];
  assign o_last = (r_bit_cnt == CNT_W'(SIZE - 1));
  assign o_par  = r_par;

endmodule

// File: rtl/uart_tx_control.sv
// UART transmit control: holding register + handshake feeding a frame FSM that
// drives start / data (LSB first) / optional parity / stop bits on TXD.
// Frame timing advances only on TXC strobes; all outputs come straight from flops.
module uart_tx_control
  import uart_pkg::*;
#(
  parameter int SIZE       = 8,     // SIZE_MIN..SIZE_MAX
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0,
  parameter int STOP_BITS  = 1      // STOP_BITS_MIN..STOP_BITS_MAX
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_txc,
  input  logic [SIZE-1:0] i_tx_data,
  input  logic            i_tx_valid,
  output logic            o_tx_ready,
  output logic            o_txd,
  output logic            o_txen,
  output logic            o_txempty
);

  tx_state_e       r_state, w_state_nxt;
  logic [SIZE-1:0] r_hold;
  logic            r_hold_full, w_hold_full_nxt;
  logic            r_tx_ready;
  logic            r_txd, w_txd_nxt;
  logic            r_txen, w_txen_nxt;
  logic            r_txempty;
  logic            r_stop_cnt;

  logic w_accept;
  logic w_load, w_shift, w_clr_cnt;
  logic w_stop_clr, w_stop_inc, w_stop_last;
  logic w_bit0, w_bit1, w_last, w_par;

  // Ready is a registered copy of "holding empty", so a write arriving on the
  // same edge as a transfer is simply taken one cycle later.
  assign w_accept    = i_tx_valid & r_tx_ready;
  assign w_stop_last = (r_stop_cnt == 1'(STOP_BITS - 1));

  uart_tx_shifter #(
    .SIZE       (SIZE),
    .PARITY_ODD (PARITY_ODD)
  ) u_shifter (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_load    (w_load),
    .i_shift   (w_shift),
    .i_clr_cnt (w_clr_cnt),
    .i_data    (r_hold),
    .o_bit0    (w_bit0),
    .o_bit1    (w_bit1),
    .o_last    (w_last),
    .o_par     (w_par)
  );

  // Next-state and next-output decode; nothing moves except on a TXC strobe.
  always_comb begin
    w_state_nxt = r_state;
    w_txd_nxt   = r_txd;
    w_txen_nxt  = r_txen;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_clr_cnt   = 1'b0;
    w_stop_clr  = 1'b0;
    w_stop_inc  = 1'b0;
    if (i_txc) begin
      case (r_state)
        IDLE: begin
          if (r_hold_full) begin
            w_state_nxt = START;
            w_txd_nxt   = 1'b0;
            w_txen_nxt  = 1'b1;
            w_load      = 1'b1;
          end
        end
        START: begin
          w_state_nxt = DATA;
          w_txd_nxt   = w_bit0;
          w_clr_cnt   = 1'b1;
        end
        DATA: begin
          if (!w_last) begin
            w_shift   = 1'b1;
            w_txd_nxt = w_bit1;
          end else if (PARITY_EN) begin
            w_state_nxt = PARITY;
            w_txd_nxt   = w_par;
          end else begin
            w_state_nxt = STOP;
            w_txd_nxt   = 1'b1;
            w_stop_clr  = 1'b1;
          end
        end
        PARITY: begin
          w_state_nxt = STOP;
          w_txd_nxt   = 1'b1;
          w_stop_clr  = 1'b1;
        end
        STOP: begin
          if (!w_stop_last) begin
            w_stop_inc = 1'b1;
          end else if (r_hold_full) begin
            // Back-to-back: next start bit follows the last stop bit directly.
            w_state_nxt = START;
            w_txd_nxt   = 1'b0;
            w_load      = 1'b1;
          end else begin
            w_state_nxt = IDLE;
            w_txen_nxt  = 1'b0;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_txd_nxt   = 1'b1;
          w_txen_nxt  = 1'b0;
        end
      endcase
    end
  end

  // Transfer and accept are mutually exclusive: a transfer needs holding full, accept needs it empty.
  assign w_hold_full_nxt = w_load ? 1'b0 : (w_accept ? 1'b1 : r_hold_full);

  // FSM state and registered line outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_txd   <= 1'b1;
      r_txen  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_txd   <= w_txd_nxt;
      r_txen  <= w_txen_nxt;
    end
  end

  // Holding register and the registered handshake / empty flags derived from it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_tx_ready  <= 1'b1;
      r_txempty   <= 1'b1;
    end else begin
      if (w_accept) r_hold <= i_tx_data;
      r_hold_full <= w_hold_full_nxt;
      r_tx_ready  <= !w_hold_full_nxt;
      r_txempty   <= (w_state_nxt == IDLE) && !w_hold_full_nxt;
    end
  end

  // Stop-bit period counter; one bit is enough for up to two stop bits.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stop_cnt <= 1'b0;
    end else if (w_stop_clr) begin
      r_stop_cnt <= 1'b0;
    end else if (w_stop_inc) begin
      r_stop_cnt <= r_stop_cnt + 1'b1;
    end
  end

  assign o_tx_ready = r_tx_ready;
  assign o_txd      = r_txd;
  assign o_txen     = r_txen;
  assign o_txempty  = r_txempty;

endmodule

// File: tb/tb_uart_tx_control.sv
// Directed bench for uart_tx_control: three instances cover no-parity/1-stop,
// even-parity/2-stop and odd-parity/1-stop. TXC pulses every 16 CLK.
module tb_uart_tx_control;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       txc    = 1'b0;
  logic       txc_en = 1'b1;
  int         txc_cnt = 0;

  logic [7:0] tx_data  [3];
  logic       tx_valid [3];
  logic       tx_ready [3];
  logic       txd      [3];
  logic       txen     [3];
  logic       txempty  [3];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_tx_control #(.SIZE(8), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(1)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_txc(txc), .i_tx_data(tx_data[0]), .i_tx_valid(tx_valid[0]),
    .o_tx_ready(tx_ready[0]), .o_txd(txd[0]), .o_txen(txen[0]), .o_txempty(txempty[0]));

  uart_tx_control #(.SIZE(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .STOP_BITS(2)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_txc(txc), .i_tx_data(tx_data[1]), .i_tx_valid(tx_valid[1]),
    .o_tx_ready(tx_ready[1]), .o_txd(txd[1]), .o_txen(txen[1]), .o_txempty(txempty[1]));

  uart_tx_control #(.SIZE(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b1), .STOP_BITS(1)) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_txc(txc), .i_tx_data(tx_data[2]), .i_tx_valid(tx_valid[2]),
    .o_tx_ready(tx_ready[2]), .o_txd(txd[2]), .o_txen(txen[2]), .o_txempty(txempty[2]));

  // Baud strobe: one CLK high every 16 CLK, gated by txc_en.
  initial begin
    forever begin
      @(negedge clk);
      txc     = txc_en && (txc_cnt == 15);
      txc_cnt = (txc_cnt == 15) ? 0 : txc_cnt + 1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // 8N1 frame in time order (bit 0 first): start, data LSB first, stop.
  function automatic logic [9:0] frame8(input logic [7:0] w);
    return {1'b1, w, 1'b0};
  endfunction

  // Present a word and hold it until the DUT takes it; returns at the negedge after acceptance.
  task automatic put_word(input int k, input logic [7:0] w);
    logic took;
    took = 1'b0;
    @(negedge clk);
    tx_data[k]  = w;
    tx_valid[k] = 1'b1;
    for (int t = 0; t < 2000; t++) begin
      if (tx_ready[k] === 1'b1) begin
        took = 1'b1;
        @(posedge clk);
        break;
      end
      @(negedge clk);
    end
    chk("accept", 64'(took), 64'(1));
    @(negedge clk);
    tx_valid[k] = 1'b0;
  endtask

  // Wait for a start bit, then sample n consecutive bit periods at mid-bit.
  task automatic get_bits(input int k, input int n, output logic [63:0] v, output logic ok);
    v  = '0;
    ok = 1'b0;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (txd[k] === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      repeat (7) @(negedge clk);
      for (int i = 0; i < n; i++) begin
        if (i > 0) repeat (16) @(negedge clk);
        v[i] = txd[k];
      end
    end
  endtask

  logic [63:0] v;
  logic        ok;
  logic        any_low;

  initial begin
    for (int k = 0; k < 3; k++) begin
      tx_data[k]  = '0;
      tx_valid[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    // Reset state
    chk("rst_txd",     64'(txd[0]),      64'(1));
    chk("rst_ready",   64'(tx_ready[0]), 64'(1));
    chk("rst_txen",    64'(txen[0]),     64'(0));
    chk("rst_txempty", 64'(txempty[0]),  64'(1));
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 1: single 0xA5 frame
    put_word(0, 8'hA5);
    chk("t1_empty_fall", 64'(txempty[0]), 64'(0));
    chk("t1_ready_fall", 64'(tx_ready[0]), 64'(0));
    get_bits(0, 10, v, ok);
    chk("t1_start", 64'(ok), 64'(1));
    chk("t1_frame", v, 64'h34A);
    chk("t1_txen_in_stop", 64'(txen[0]), 64'(1));
    repeat (16) @(negedge clk);
    chk("t1_txempty_after", 64'(txempty[0]), 64'(1));
    chk("t1_txen_after", 64'(txen[0]), 64'(0));
    repeat (40) @(negedge clk);

    // 2: back-to-back 0x3C then 0xC3, no idle gap
    fork
      begin
        put_word(0, 8'h3C);
        put_word(0, 8'hC3);
        chk("t2_ready_low0", 64'(tx_ready[0]), 64'(0));
        repeat (50) @(negedge clk);
        chk("t2_ready_low1", 64'(tx_ready[0]), 64'(0));
      end
      get_bits(0, 20, v, ok);
    join
    chk("t2_start", 64'(ok), 64'(1));
    chk("t2_frames", v, 64'({frame8(8'hC3), frame8(8'h3C)}));
    repeat (40) @(negedge clk);

    // 3: parity and two stop bits
    put_word(1, 8'h07);
    get_bits(1, 12, v, ok);
    chk("t3_even_start", 64'(ok), 64'(1));
    chk("t3_even_frame", v, 64'hE0E);
    chk("t3_even_par", 64'(v[9]), 64'(1));
    chk("t3_txen_stop2", 64'(txen[1]), 64'(1));
    repeat (16) @(negedge clk);
    chk("t3_txen_done", 64'(txen[1]), 64'(0));
    chk("t3_empty_done", 64'(txempty[1]), 64'(1));
    put_word(2, 8'h07);
    get_bits(2, 11, v, ok);
    chk("t3_odd_start", 64'(ok), 64'(1));
    chk("t3_odd_frame", v, 64'h40E);
    chk("t3_odd_par", 64'(v[9]), 64'(0));
    repeat (40) @(negedge clk);

    // 4: streamed words, valid held across transfer edges; every word once, in order
    fork
      begin
        put_word(0, 8'h11);
        put_word(0, 8'h22);
        put_word(0, 8'h80);
        put_word(0, 8'hFE);
      end
      get_bits(0, 40, v, ok);
    join
    chk("t4_start", 64'(ok), 64'(1));
    chk("t4_stream", v, 64'({frame8(8'hFE), frame8(8'h80), frame8(8'h22), frame8(8'h11)}));
    repeat (16) @(negedge clk);
    chk("t4_empty", 64'(txempty[0]), 64'(1));
    repeat (30) @(negedge clk);

    // 5: reset during data bit 4, then a clean frame
    put_word(0, 8'h00);
    get_bits(0, 6, v, ok);
    chk("t5_start", 64'(ok), 64'(1));
    chk("t5_partial", v, 64'h0);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_txd",   64'(txd[0]),      64'(1));
    chk("t5_rst_txen",  64'(txen[0]),     64'(0));
    chk("t5_rst_ready", 64'(tx_ready[0]), 64'(1));
    chk("t5_rst_empty", 64'(txempty[0]),  64'(1));
    repeat (20) @(negedge clk);
    chk("t5_rst_hold_txd", 64'(txd[0]), 64'(1));
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    put_word(0, 8'h55);
    get_bits(0, 10, v, ok);
    chk("t5_post_start", 64'(ok), 64'(1));
    chk("t5_post_frame", v, 64'h2AA);
    repeat (40) @(negedge clk);

    // 6: TXC stalled with a word pending
    txc_en  = 1'b0;
    put_word(0, 8'h81);
    any_low = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (txd[0] !== 1'b1) any_low = 1'b1;
    end
    chk("t6_txd_high",  64'(any_low),     64'(0));
    chk("t6_ready_low", 64'(tx_ready[0]), 64'(0));
    chk("t6_empty_low", 64'(txempty[0]),  64'(0));
    txc_en = 1'b1;
    get_bits(0, 10, v, ok);
    chk("t6_start", 64'(ok), 64'(1));
    chk("t6_frame", v, 64'h302);
    repeat (30) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
